hit_uart_readout: RTL and testbench

Readout stage downstream of the TDC hit FIFO. It drains 8-bit timing words ({2'b00, coarse[2:0], fine[2:0]}) through the FIFO's non-first-word-fall-through read port and serialises each one as 8N1 UART on a single TX line for host capture. It runs entirely in the SYSCLK domain, the same clock that writes the FIFO.

---
 rtl/hit_uart_readout_if.sv | 8 +
 rtl/hit_uart_readout.sv | 104 ++++++++++
 tb/tb_hit_uart_readout.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hit_uart_readout_if.sv
// hit_uart_readout_if: read-port bundle between the TDC hit FIFO and the UART readout.
interface hit_uart_readout_if;
    logic       fifo_data_available;
    logic       read_fifo;
    logic [7:0] fifo_dout;
    modport master (input fifo_data_available, input fifo_dout, output read_fifo);
    modport slave (output fifo_data_available, output fifo_dout, input read_fifo);
endinterface

// File: rtl/hit_uart_readout.sv
// hit_uart_readout: pops 8-bit TDC hit words from a non-FWFT FIFO and sends each as 8N1 UART on txd.
// Optional macro TDC_READOUT_SEQ_EN: every hit is preceded by a {4'hA, seq[3:0]} header byte.
module hit_uart_readout #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic               SYSCLK,
    input  logic               RESET_N,
    hit_uart_readout_if.master fifo,
    output logic               txd,
    output logic               busy,
    output logic [15:0]        hit_count
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, POP, LATCH, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    data_q;
    logic [7:0]    tx_byte;
    logic          bit_done;
    logic          last_byte;
    logic          hit_done;

`ifdef TDC_READOUT_SEQ_EN
    logic [3:0] seq;
    logic       hdr;
    assign tx_byte   = hdr ? {4'hA, seq} : data_q;
    assign last_byte = ~hdr;
`else
    assign tx_byte   = data_q;
    assign last_byte = 1'b1;
`endif

    assign bit_done = (baud == BAUD_LAST);
    assign hit_done = (state == STOP) && bit_done && last_byte;

    // State register; reset forces IDLE so txd returns high at once.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and the state-decoded outputs (pop strobe, line level, busy).
    always_comb begin
        state_nxt      = state;
        fifo.read_fifo = 1'b0;
        txd            = 1'b1;
        busy           = 1'b1;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                state_nxt = fifo.fifo_data_available ? POP : IDLE;
            end
            POP: begin
                fifo.read_fifo = 1'b1;
                state_nxt      = LATCH;
            end
            LATCH: state_nxt = START;
            START: begin
                txd       = 1'b0;
                state_nxt = bit_done ? DATA : START;
            end
            DATA: begin
                txd       = tx_byte[bit_idx];
                state_nxt = (bit_done && bit_idx == 3'd7) ? STOP : DATA;
            end
            STOP: state_nxt = bit_done ? (last_byte ? IDLE : START) : STOP;
            default: state_nxt = IDLE;
        endcase
    end

    // Baud/bit counters, word capture and delivered-hit counter.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            baud      <= '0;
            bit_idx   <= '0;
            data_q    <= '0;
            hit_count <= '0;
        end else begin
            baud      <= (state inside {START, DATA, STOP} && !bit_done) ? baud + BW'(1) : '0;
            bit_idx   <= (state == DATA && bit_done) ? bit_idx + 3'd1 : bit_idx;
            data_q    <= (state == LATCH) ? fifo.fifo_dout : data_q;
            hit_count <= hit_count + {15'd0, hit_done};
        end
    end

`ifdef TDC_READOUT_SEQ_EN
    // Header-phase flag (set on latch, cleared after the header stop bit) and per-hit sequence number.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            seq <= '0;
            hdr <= 1'b0;
        end else begin
            hdr <= (state == LATCH) ? 1'b1 : (state == STOP && bit_done) ? 1'b0 : hdr;
            seq <= hit_done ? seq + 4'd1 : seq;
        end
    end
`endif
endmodule

// File: tb/tb_hit_uart_readout.sv
// tb_hit_uart_readout: self-checking bench for hit_uart_readout at CLKS_PER_BIT=4; follows TDC_READOUT_SEQ_EN.
module tb_hit_uart_readout;
    localparam int C  = 4;
    localparam int FR = 10 * C;
`ifdef TDC_READOUT_SEQ_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int HIT = FR * NB + 3;

    typedef struct packed {
        logic [7:0] w;
        logic [9:0] fr;
    } vec_t;

    logic        SYSCLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        txd, busy;
    logic [15:0] hit_count;

    hit_uart_readout_if bus();

    hit_uart_readout #(.CLKS_PER_BIT(C)) dut (
        .SYSCLK(SYSCLK),
        .RESET_N(RESET_N),
        .fifo(bus),
        .txd(txd),
        .busy(busy),
        .hit_count(hit_count)
    );

    always #5 SYSCLK = ~SYSCLK;

    int         n_cmp = 0, n_bad = 0;
    logic [7:0] fq[$];
    bit         avail_en = 1'b1;
    logic [7:0] exp_q[$];
    logic [3:0] seq_m = 4'd0;
    int         exp_hits = 0;
    bit         rec = 1'b0;
    logic       tr_txd[$], tr_rd[$], tr_busy[$];

    // FIFO model: registered not-empty flag, data valid the cycle after a pop.
    always @(posedge SYSCLK) begin
        logic [7:0] w;
        if (bus.read_fifo === 1'b1 && fq.size() > 0) begin
            w = fq.pop_front();
            bus.fifo_dout <= w;
        end
        bus.fifo_data_available <= avail_en && fq.size() > 0;
    end

    // Per-cycle trace of the outputs, sampled mid-cycle.
    always @(negedge SYSCLK) begin
        if (rec) begin
            tr_txd.push_back(txd);
            tr_rd.push_back(bus.read_fifo);
            tr_busy.push_back(busy);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check_int(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Expected byte stream: optional header, then the word; one hit each.
    task automatic push_word(input logic [7:0] w);
`ifdef TDC_READOUT_SEQ_EN
        exp_q.push_back({4'hA, seq_m});
        seq_m = seq_m + 4'd1;
`endif
        exp_q.push_back(w);
        exp_hits++;
        fq.push_back(w);
    endtask

    task automatic start_trace();
        tr_txd.delete();
        tr_rd.delete();
        tr_busy.delete();
        rec = 1'b1;
    endtask

    task automatic wait_drain(input string nm, input int max_cyc);
        int n = 0;
        int quiet = 0;
        while (n < max_cyc && !(fq.size() == 0 && quiet >= 4)) begin
            @(negedge SYSCLK);
            n++;
            quiet = (busy === 1'b0) ? quiet + 1 : 0;
        end
        if (n >= max_cyc) check_int({nm, "_drain_timeout"}, n, 0);
        @(posedge SYSCLK);
        #2;
        rec = 1'b0;
    endtask

    task automatic wait_pop(input string nm, output int p);
        int n = 0;
        do begin
            @(posedge SYSCLK);
            #2;
            n++;
        end while (bus.read_fifo !== 1'b1 && n < 60);
        check_int({nm, "_pop_seen"}, int'(bus.read_fifo === 1'b1), 1);
        p = tr_rd.size();
    endtask

    function automatic int pop_at(input int j);
        int c = 0;
        foreach (tr_rd[i]) if (tr_rd[i] === 1'b1) begin
            if (c == j) return i;
            c++;
        end
        return -1;
    endfunction

    function automatic logic txd_at(input int i);
        return (i >= 0 && i < tr_txd.size()) ? tr_txd[i] : 1'bx;
    endfunction

    // Frame starting at cycle s, first transmitted bit in bit 9, sampled at bit centres.
    function automatic logic [9:0] frame_at(input int s);
        logic [9:0] f;
        f = '1;
        for (int k = 0; k < 10; k++) f[9-k] = txd_at(s + C * k + C / 2);
        return f;
    endfunction

    // Check pops, exact txd/busy waveforms derived from the pops, and decoded bytes against the model.
    task automatic check_trace(input string nm, input int n_words);
        int n, k, bad_w, bad_g, bad_t, bad_b;
        int pops[$];
        logic et[$], eb[$];
        logic [7:0] got[$];
        logic [7:0] b;
        logic [9:0] f;
        n = tr_txd.size();
        foreach (tr_rd[i]) if (tr_rd[i] === 1'b1) pops.push_back(i);
        check_int({nm, "_pops"}, pops.size(), n_words);
        bad_w = 0;
        for (int i = 1; i < n; i++) if (tr_rd[i] === 1'b1 && tr_rd[i-1] === 1'b1) bad_w++;
        check_int({nm, "_pop_width"}, bad_w, 0);
        bad_g = 0;
        for (int j = 1; j < pops.size(); j++) if (pops[j] - pops[j-1] < HIT) bad_g++;
        check_int({nm, "_pop_gap"}, bad_g, 0);
        for (int i = 0; i < n; i++) begin
            et.push_back(1'b1);
            eb.push_back(1'b0);
        end
        k = 0;
        foreach (pops[j]) begin
            for (int i = pops[j]; i <= pops[j] + 1 + FR * NB && i < n; i++) eb[i] = 1'b1;
            for (int m = 0; m < NB; m++) begin
                b = (k < exp_q.size()) ? exp_q[k] : 8'h00;
                k++;
                for (int t = 0; t < FR; t++) begin
                    int idx = pops[j] + 2 + FR * m + t;
                    int bn = t / C;
                    if (idx < n) et[idx] = (bn == 0) ? 1'b0 : (bn == 9) ? 1'b1 : b[bn-1];
                end
            end
        end
        bad_t = 0;
        bad_b = 0;
        for (int i = 0; i < n; i++) begin
            if (tr_txd[i] !== et[i]) bad_t++;
            if (tr_busy[i] !== eb[i]) bad_b++;
        end
        check_int({nm, "_txd_cycles_wrong"}, bad_t, 0);
        check_int({nm, "_busy_cycles_wrong"}, bad_b, 0);
        k = 0;
        while (k + FR <= n) begin
            if (tr_txd[k] === 1'b0) begin
                f = frame_at(k);
                for (int j = 0; j < 8; j++) b[j] = f[8-j];
                got.push_back(b);
                k += FR;
            end else k++;
        end
        check_int({nm, "_byte_count"}, got.size(), n_words * NB);
        foreach (got[j]) if (j < exp_q.size()) check_int($sformatf("%s_byte%0d", nm, j), int'(got[j]), int'(exp_q[j]));
        repeat (n_words * NB) if (exp_q.size() > 0) void'(exp_q.pop_front());
        check_int({nm, "_hit_count"}, int'(hit_count), exp_hits);
    endtask

    initial begin
        vec_t tbl[8];
        int p, nw, zeros;
        tbl[0] = '{8'h2D, 10'b0101101001};
        tbl[1] = '{8'h00, 10'b0000000001};
        tbl[2] = '{8'hFF, 10'b0111111111};
        tbl[3] = '{8'h01, 10'b0100000001};
        tbl[4] = '{8'h3F, 10'b0111111001};
        tbl[5] = '{8'h80, 10'b0000000011};
        tbl[6] = '{8'hA5, 10'b0101001011};
        tbl[7] = '{8'h3C, 10'b0001111001};

        // Reset held with data available, then release and send one word.
        push_word(8'h2D);
        repeat (5) @(posedge SYSCLK);
        #2;
        check_int("rst_txd", int'(txd), 1);
        check_int("rst_read_fifo", int'(bus.read_fifo), 0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_hit_count", int'(hit_count), 0);
        start_trace();
        RESET_N = 1'b1;
        wait_drain("single", 300);
        p = pop_at(0);
        check_int("release_pop_cycle", p, 1);
        check_int("single_start_edge", int'({txd_at(p + 1), txd_at(p + 2)}), 2);
        check_int("single_frame", int'(frame_at(p + 2 + FR * (NB - 1))), int'(10'b0101101001));
        check_trace("single", 1);

        // Table of single words with hand-derived line patterns.
        foreach (tbl[i]) begin
            start_trace();
            push_word(tbl[i].w);
            wait_drain($sformatf("tbl%0d", i), 300);
            check_int($sformatf("tbl%0d_frame", i), int'(frame_at(pop_at(0) + 2 + FR * (NB - 1))), int'(tbl[i].fr));
            check_trace($sformatf("tbl%0d", i), 1);
        end

        // Back-to-back words with the FIFO never empty.
        start_trace();
        push_word(8'h01);
        push_word(8'h3F);
        push_word(8'h00);
        wait_drain("b2b", 600);
        check_int("b2b_gap01", pop_at(1) - pop_at(0), HIT);
        check_int("b2b_gap12", pop_at(2) - pop_at(1), HIT);
        check_trace("b2b", 3);

        // Availability drops mid-frame, returns either in the stop bit or after IDLE is reached.
        for (int v = 0; v < 2; v++) begin
            int r = (v == 0) ? FR * NB - 1 : FR * NB + 9;
            start_trace();
            push_word(8'h5A);
            push_word(8'h13);
            wait_pop($sformatf("late%0d", v), p);
            repeat (10) @(posedge SYSCLK);
            #2;
            avail_en = 1'b0;
            repeat (r - 10) @(posedge SYSCLK);
            #2;
            avail_en = 1'b1;
            wait_drain($sformatf("late%0d", v), 600);
            check_int($sformatf("late%0d_gap", v), pop_at(1) - pop_at(0), (r + 2 > HIT) ? r + 2 : HIT);
            check_trace($sformatf("late%0d", v), 2);
        end

        // Random words with random availability.
        start_trace();
        nw = 0;
        for (int i = 0; i < 12; i++) begin
            push_word({2'b00, 6'($urandom_range(0, 63))});
            nw++;
        end
        for (int i = 0; i < 500; i++) begin
            @(posedge SYSCLK);
            #2;
            avail_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) begin
                push_word({2'b00, 6'($urandom_range(0, 63))});
                nw++;
            end
        end
        avail_en = 1'b1;
        wait_drain("rand", 6000);
        check_trace("rand", nw);

        // Fresh reset, then 17 consecutive words (sequence number wraps once).
        RESET_N = 1'b0;
        seq_m = 4'd0;
        exp_hits = 0;
        repeat (3) @(posedge SYSCLK);
        #2;
        RESET_N = 1'b1;
        start_trace();
        for (int i = 0; i < 17; i++) push_word(8'((i * 7) & 8'h3F));
        wait_drain("seq17", 2500);
`ifdef TDC_READOUT_SEQ_EN
        check_int("seq17_hdr15", int'(frame_at(pop_at(15) + 2)), int'(10'b0111101011));
        check_int("seq17_hdr16", int'(frame_at(pop_at(16) + 2)), int'(10'b0000001011));
`endif
        check_trace("seq17", 17);

        // Reset asserted during data bit 3 of a zero word.
        start_trace();
        push_word(8'h00);
        wait_pop("midrst", p);
        repeat (19 + FR * (NB - 1)) @(posedge SYSCLK);
        #2;
        check_int("midrst_pre_txd", int'(txd), 0);
        RESET_N = 1'b0;
        #1;
        check_int("midrst_txd", int'(txd), 1);
        check_int("midrst_busy", int'(busy), 0);
        check_int("midrst_read_fifo", int'(bus.read_fifo), 0);
        exp_q.delete();
        seq_m = 4'd0;
        exp_hits = 0;
        rec = 1'b0;
        repeat (3) @(posedge SYSCLK);
        #2;
        start_trace();
        RESET_N = 1'b1;
        repeat (60) @(posedge SYSCLK);
        #2;
        rec = 1'b0;
        zeros = 0;
        foreach (tr_txd[i]) if (tr_txd[i] !== 1'b1) zeros++;
        check_int("midrst_after_low_cycles", zeros, 0);
        check_int("midrst_after_pop", pop_at(0), -1);
        check_int("midrst_hit_count", int'(hit_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
